bram_stream_reader: RTL and testbench

- Read-side initiator for one port of the team's dual-port BRAM.
- On a start command it issues a burst of sequential reads (base address, length) on that BRAM port.
- Captures each returned word using the port's data-acknowledge signal and emits the words on a valid/ready stream toward the filter datapath.
- A small internal FIFO absorbs downstream backpressure; reads are credit-gated so no returned word is ever dropped.

---
 rtl/bram_stream_pkg.sv | 31 +++
 rtl/bram_stream_fifo.sv | 68 ++++++
 rtl/bram_stream_reader.sv | 158 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_stream_pkg: shared encodings, defaults and helpers for the BRAM reader.
// Rev 1.0
// ----------------------------------------------------------------------------
package bram_stream_pkg;

  localparam int DEF_INDEXWIDTH = 9;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_stream_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_stream_fifo: synchronous FIFO with occupancy count (power-of-2 depth).
// Rev 1.0
// ----------------------------------------------------------------------------
module bram_stream_fifo
  import bram_stream_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W     = clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             ssr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ssr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_stream_reader: credit-gated burst reader from one BRAM port to a stream.
// Optional BRAM_STREAM_LAST_EN adds m_last marking the final word of a burst.
// Rev 1.0
// ----------------------------------------------------------------------------
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int INDEXWIDTH = DEF_INDEXWIDTH,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LENWIDTH   = INDEXWIDTH + 1,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  ssr,
  input  logic                  start,
  input  logic [INDEXWIDTH-1:0] base_addr,
  input  logic [LENWIDTH-1:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  bram_ssr,
  output logic [INDEXWIDTH-1:0] bram_addr,
  output logic [WIDTH-1:0]      bram_din,
  input  logic [WIDTH-1:0]      bram_dout,
  input  logic                  bram_dack,
  output logic                  m_valid,
  output logic [WIDTH-1:0]      m_data,
  input  logic                  m_ready
`ifdef BRAM_STREAM_LAST_EN
  ,
  output logic                  m_last
`endif
);

  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [LENWIDTH-1:0]   remaining_q, remaining_d;
  logic [INDEXWIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic                  zero_done_q, zero_done_d;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W:0]        occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  last_pop;

`ifdef BRAM_STREAM_LAST_EN
  localparam int FIFO_W = WIDTH + 1;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;
  // A word captured once nothing remains to issue is the burst's final word.
  assign fifo_din = {(remaining_q == '0), bram_dout};
  assign m_data   = fifo_dout[WIDTH-1:0];
  assign m_last   = m_valid && fifo_dout[WIDTH];
`else
  localparam int FIFO_W = WIDTH;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;
  assign fifo_din = bram_dout;
  assign m_data   = fifo_dout;
`endif

  bram_stream_fifo #(
    .WIDTH      (FIFO_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .ssr   (ssr),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credit check: every issued read already owns a FIFO slot when it returns.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue     = (state_q == ST_RUN) && (remaining_q != '0) && !fifo_full &&
                     (occupancy < OCC_LIMIT);
  assign push      = bram_dack && inflight_q;
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign last_pop  = (state_q == ST_DRAIN) && !inflight_q &&
                     (fifo_count == CNT_W'(1)) && pop;

  assign busy      = (state_q != ST_IDLE) || zero_done_q;
  assign done      = zero_done_q || last_pop;
  assign bram_en   = issue;
  assign bram_addr = addr_q;
  assign bram_we   = 1'b0;
  assign bram_ssr  = 1'b0;
  assign bram_din  = '0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    inflight_d  = issue;
    zero_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !zero_done_q) begin
          addr_d      = base_addr;
          remaining_d = len;
          if (len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          remaining_d = remaining_q - LENWIDTH'(1);
          addr_d      = addr_q + INDEXWIDTH'(1);
          if (remaining_q == LENWIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (last_pop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ssr) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bram_stream_reader: scoreboard bench with a BRAM model and random traffic.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bram_stream_reader;

  localparam int IW = 9;
  localparam int W  = 8;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          ssr;
  logic          start;
  logic [IW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy, done, bram_en, bram_we, bram_ssr;
  logic [IW-1:0] bram_addr;
  logic [W-1:0]  bram_din;
  logic [W-1:0]  bram_dout;
  logic          bram_dack;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready;
`ifdef BRAM_STREAM_LAST_EN
  logic          m_last;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         last;
  } item_t;

  item_t         exp_q[$];
  logic [W-1:0]  ram [1<<IW];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            busy_model = 1'b0;
  bit            zero_pending = 1'b0;
  int            issue_left = 0;
  logic [IW-1:0] exp_addr = '0;
  int            outst = 0;
  int            rst_chk = 0;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_data = '0;
  int            rmode = 0;

  bram_stream_reader #(
    .INDEXWIDTH (IW),
    .WIDTH      (W),
    .LENWIDTH   (LW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .ssr       (ssr),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_ssr  (bram_ssr),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout),
    .bram_dack (bram_dack),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
`ifdef BRAM_STREAM_LAST_EN
    ,
    .m_last    (m_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM port model: one-cycle read latency with acknowledge.
  initial begin : bram_model
    logic          en;
    logic [IW-1:0] a;
    bram_dack = 1'b0;
    bram_dout = '0;
    forever begin
      @(negedge clk);
      en = bram_en;
      a  = bram_addr;
      @(posedge clk);
      #1;
      bram_dack = en;
      if (en) bram_dout = ram[a];
    end
  end

  initial begin : ready_driver
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: begin
          m_ready = pat[ph];
          ph = (ph + 1) % 4;
        end
        2: m_ready = ($urandom_range(0, 99) < 60);
        default: m_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    item_t it;
    bit    xfer;
    bit    exp_done;
    xfer     = m_valid && m_ready;
    exp_done = zero_pending;
    chk("const_bram_outputs", {bram_we, bram_ssr, bram_din}, '0);
    if (rst_chk > 0) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_bram_addr", bram_addr, 0);
      rst_chk--;
    end
`ifdef BRAM_STREAM_LAST_EN
    if (!m_valid) chk("m_last_idle", m_last, 0);
`endif
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        it = exp_q.pop_front();
        chk("m_data", m_data, it.d);
`ifdef BRAM_STREAM_LAST_EN
        chk("m_last", m_last, it.last);
`endif
        if (it.last) exp_done = 1'b1;
      end
    end
    chk("done", done, exp_done);
    chk("busy", busy, busy_model);
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
    end
    if (bram_en) begin
      chk("issue_allowed", issue_left > 0, 1);
      chk("issue_credit", outst < 4, 1);
      chk("bram_addr", bram_addr, exp_addr);
      exp_addr = exp_addr + 1'b1;
      issue_left--;
      outst++;
    end
    if (xfer) outst--;
    if (exp_done) begin
      busy_model   = 1'b0;
      zero_pending = 1'b0;
    end
    prev_stall = m_valid && !m_ready && !ssr;
    prev_data  = m_data;
    if (ssr) begin
      exp_q.delete();
      busy_model   = 1'b0;
      zero_pending = 1'b0;
      issue_left   = 0;
      outst        = 0;
      rst_chk      = 2;
    end
  end

  task automatic do_start(input logic [IW-1:0] b, input logic [LW-1:0] l, input bit accept);
    logic [IW-1:0] a;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    len       = l;
    if (accept) begin
      for (int i = 0; i < int'(l); i++) begin
        a = b + IW'(i);
        exp_q.push_back('{d: ram[a], last: (i == int'(l) - 1)});
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accept) begin
      busy_model = 1'b1;
      exp_addr   = b;
      issue_left = int'(l);
      if (l == '0) zero_pending = 1'b1;
    end
  endtask

  task automatic start_in_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    start     = 1'b1;
    base_addr = IW'($urandom);
    len       = LW'($urandom_range(0, 30));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy_model && busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", ok, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [IW-1:0] ba;
    logic [LW-1:0] ln;
    bit mid, ind;
    int n;
    for (int i = 0; i < (1 << IW); i++) ram[i] = W'(i);
    ssr = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    repeat (3) @(posedge clk);
    #1;
    ssr = 1'b0;

    // Latency and throughput from address 5.
    do_start(9'd5, 10'd4, 1);
    @(negedge clk);
    chk("first_en", bram_en, 1);
    chk("first_addr", bram_addr, 5);
    @(negedge clk);
    chk("valid_t2", m_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("valid_stream", m_valid, 1);
    end
    wait_idle();

    // Address wrap at the top of memory.
    do_start(9'd510, 10'd4, 1);
    wait_idle();

    // Backpressure 1-0-0-1.
    rmode = 1;
    do_start(IW'($urandom), 10'd16, 1);
    wait_idle();
    rmode = 0;

    // Zero-length burst.
    do_start(9'd77, 10'd0, 1);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("zero_no_en", bram_en, 0);
      chk("zero_no_valid", m_valid, 0);
    end

    // Reset while word 3 of 8 is being issued.
    do_start(9'd100, 10'd8, 1);
    n = 0;
    for (int k = 0; k < 50 && n < 2; k++) begin
      @(negedge clk);
      if (bram_en) n++;
    end
    @(posedge clk);
    #1;
    ssr = 1'b1;
    @(negedge clk);
    chk("rst_at_issue3", bram_en, 1);
    @(posedge clk);
    #1;
    ssr = 1'b0;
    do_start(9'd0, 10'd2, 1);
    wait_idle();

    // Starts during a burst and in its done cycle are ignored.
    do_start(IW'($urandom), 10'd12, 1);
    do_start(IW'($urandom), LW'($urandom_range(0, 30)), 0);
    repeat (3) @(posedge clk);
    do_start(IW'($urandom), LW'($urandom_range(0, 30)), 0);
    start_in_done();
    wait_idle();
    repeat (5) @(negedge clk);

    // Random traffic over random memory contents.
    for (int i = 0; i < (1 << IW); i++) ram[i] = W'($urandom);
    rmode = 2;
    for (int b = 0; b < 25; b++) begin
      ba  = IW'($urandom);
      ln  = ($urandom_range(0, 9) == 0) ? '0 : LW'($urandom_range(1, 24));
      mid = 1'($urandom_range(0, 1));
      ind = ($urandom_range(0, 2) == 0);
      do_start(ba, ln, 1);
      if (mid) do_start(IW'($urandom), LW'($urandom_range(0, 30)), 0);
      if (ind && (ln != '0 || !mid)) start_in_done();
      wait_idle();
    end
    rmode = 0;
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
